// File: rtl/matrix_input_loader.sv
// matrix_input_loader
// Collects a row-major byte stream into two NxN operand matrices (A, then B).
// Once both are loaded it strobes the multiplier's input-valid for one cycle.
// It then refuses further bytes until the multiplier returns its result-valid.
// The matrices are held stable from the start strobe until the next load
// overwrites them element by element.

module matrix_input_loader #(
    parameter int N = 4
) (
    input  logic                    i_clk,
    input  logic                    i_arst,
    input  logic                    i_clear,
    input  logic [7:0]              i_data,
    input  logic                    i_valid,
    output logic                    o_ready,
    output logic [N-1:0][N-1:0][7:0] o_a,
    output logic [N-1:0][N-1:0][7:0] o_b,
    output logic                    o_validInput,
    input  logic                    i_validResult,
    output logic                    o_busy
);

    if ((N < 3) || (N > 256)) begin : g_bad_n
        $error("matrix_input_loader: N must be in 3..256");
    end

    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    typedef enum logic [1:0] {
        ST_LOAD_A = 2'd0,
        ST_LOAD_B = 2'd1,
        ST_FIRE   = 2'd2,
        ST_WAIT   = 2'd3
    } state_t;

    state_t                     state_q, state_d;
    logic [CW-1:0]              row_q, row_d;
    logic [CW-1:0]              col_q, col_d;
    logic [N-1:0][N-1:0][7:0]   a_q, a_d;
    logic [N-1:0][N-1:0][7:0]   b_q, b_d;
    logic                       ready_q, ready_d;
    logic                       valid_input_q, valid_input_d;
    logic                       busy_q, busy_d;

    logic                       beat_s;
    logic                       last_elem_s;
    logic [CW-1:0]              row_next_s;
    logic [CW-1:0]              col_next_s;

    // Handshake qualification and row-major index advance (explicit wrap compare, no modulo).
    always_comb begin
        beat_s      = i_valid && ready_q;
        last_elem_s = (row_q == LAST_IDX) && (col_q == LAST_IDX);
        if (col_q == LAST_IDX) begin
            col_next_s = {CW{1'b0}};
            if (row_q == LAST_IDX) begin
                row_next_s = {CW{1'b0}};
            end else begin
                row_next_s = row_q + {{(CW-1){1'b0}}, 1'b1};
            end
        end else begin
            col_next_s = col_q + {{(CW-1){1'b0}}, 1'b1};
            row_next_s = row_q;
        end
    end

    // Next-state, matrix write and registered-output decode; clear overrides everything but storage.
    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        a_d     = a_q;
        b_d     = b_q;

        if (i_clear) begin
            state_d = ST_LOAD_A;
            row_d   = {CW{1'b0}};
            col_d   = {CW{1'b0}};
        end else begin
            case (state_q)
                ST_LOAD_A: begin
                    if (beat_s) begin
                        a_d[row_q][col_q] = i_data;
                        row_d = row_next_s;
                        col_d = col_next_s;
                        if (last_elem_s) begin
                            state_d = ST_LOAD_B;
                        end else begin
                            state_d = ST_LOAD_A;
                        end
                    end else begin
                        state_d = ST_LOAD_A;
                    end
                end
                ST_LOAD_B: begin
                    if (beat_s) begin
                        b_d[row_q][col_q] = i_data;
                        row_d = row_next_s;
                        col_d = col_next_s;
                        if (last_elem_s) begin
                            state_d = ST_FIRE;
                        end else begin
                            state_d = ST_LOAD_B;
                        end
                    end else begin
                        state_d = ST_LOAD_B;
                    end
                end
                ST_FIRE: begin
                    state_d = ST_WAIT;
                end
                ST_WAIT: begin
                    if (i_validResult) begin
                        state_d = ST_LOAD_A;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
                default: begin
                    state_d = ST_LOAD_A;
                    row_d   = {CW{1'b0}};
                    col_d   = {CW{1'b0}};
                end
            endcase
        end

        ready_d       = (state_d == ST_LOAD_A) || (state_d == ST_LOAD_B);
        valid_input_d = (state_d == ST_FIRE);
        busy_d        = (state_d == ST_FIRE) || (state_d == ST_WAIT);
    end

    // State, counters, matrices and decoded outputs; async reset zeroes any partial load.
    always_ff @(posedge i_clk or posedge i_arst) begin
        if (i_arst) begin
            state_q       <= ST_LOAD_A;
            row_q         <= {CW{1'b0}};
            col_q         <= {CW{1'b0}};
            a_q           <= '0;
            b_q           <= '0;
            ready_q       <= 1'b1;
            valid_input_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            row_q         <= row_d;
            col_q         <= col_d;
            a_q           <= a_d;
            b_q           <= b_d;
            ready_q       <= ready_d;
            valid_input_q <= valid_input_d;
            busy_q        <= busy_d;
        end
    end

    assign o_ready      = ready_q;
    assign o_a          = a_q;
    assign o_b          = b_q;
    assign o_validInput = valid_input_q;
    assign o_busy       = busy_q;

endmodule

// File: doc/matrix_input_loader.md
Name: matrix_input_loader

Overview:
- Upstream feeder for the systolic-array multiplier top.
- Accepts a byte stream of matrix elements over a valid/ready handshake and assembles full NxN operand matrices A and B.
- Presents A and B to the multiplier, pulses its input-valid strobe, then blocks new loads until the multiplier reports its result valid.

Parameters:
- N, 4, matrix dimension; legal range 3..256; elaboration error outside this range.

Ports:
- i_clk  in  1  clock
- i_arst  in  1  reset, asynchronous, active-high
- i_clear  in  1  synchronous abort; returns to LOAD_A
- i_data  in  8  element byte
- i_valid  in  1  i_data valid
- o_ready  out  1  loader can accept i_data this cycle
- o_a  out  N*N*8  matrix A, [row][col][7:0]; drives multiplier i_a
- o_b  out  N*N*8  matrix B, [row][col][7:0]; drives multiplier i_b
- o_validInput  out  1  one-cycle start strobe to multiplier
- i_validResult  in  1  multiplier result-valid pulse; releases loader
- o_busy  out  1  high while a multiplication is outstanding (FIRE or WAIT)

Behaviour:
- Reset state: state=LOAD_A, row/col counters=0, o_a=0, o_b=0, o_validInput=0, o_busy=0. o_ready=1 from the first cycle after reset.
- Beat: a transfer occurs when i_valid && o_ready at a rising edge. Non-handshaked cycles change nothing.
- Element order: row-major, A first, then B. Beat k of A writes o_a[k/N][k%N]; beat k of B writes o_b[k/N][k%N]. 2*N*N beats per operation.
- Counters: col index and row index, each $clog2(N) bits (min 1 bit). col wraps N-1→0 and increments row; row wraps N-1→0 at end of matrix. No modulo arithmetic on non-power-of-2 N: compare against N-1 explicitly.
- FSM:
  - LOAD_A: o_ready=1. Beat at row=col=N-1 → LOAD_B.
  - LOAD_B: o_ready=1. Beat at row=col=N-1 → FIRE.
  - FIRE: o_ready=0. o_validInput=1 for exactly this cycle. Always → WAIT next cycle.
  - WAIT: o_ready=0. i_validResult=1 → LOAD_A.
- Latency:
  - Last B beat accepted at edge t → o_validInput high in cycle t..t+1 (registered, not combinational from i_valid).
  - i_validResult seen at edge u → o_ready=1 from edge u onward.
- o_validInput is a registered output (state==FIRE decoded into a flop or equivalent glitch-free signal).
- o_busy is high in FIRE and WAIT.
- Data stability:
  - o_a/o_b change only on accepted beats in their own load state.
  - They are held constant through FIRE and WAIT, so the multiplier samples a stable matrix.
  - They are not cleared between operations; the next load overwrites them element by element.
- i_validResult outside WAIT is ignored; it is neither stored nor counted.
- i_clear (synchronous, priority over all FSM transitions):
  - Next state=LOAD_A, counters=0, o_validInput=0 for that cycle's update.
  - Matrix storage is untouched.
  - A beat presented in the same cycle as i_clear is dropped (not written).
  - Clear during WAIT releases the loader; the caller owns any in-flight multiplier result.
- Reset mid-operation: all state returns to reset values immediately (async). A partially loaded matrix is discarded by zeroing.
- i_data is don't-care when i_valid=0. X on i_data without i_valid must not propagate into o_a/o_b.

Test Plan:
- N=4, reset, stream bytes 1..32 with i_valid constant → o_a[0][0]=1, o_a[3][3]=16, o_b[0][0]=17, o_b[2][1]=26; o_validInput high exactly 1 cycle, one cycle after beat 32; o_ready=0 thereafter.
- Backpressure/gaps: same 32 bytes with i_valid toggled pseudo-randomly → identical o_a/o_b; beat count governed only by handshakes; o_validInput once.
- WAIT blocking: after FIRE, hold i_valid=1, data=0xFF for 20 cycles → o_a/o_b unchanged, o_ready=0; pulse i_validResult → o_ready=1 next cycle; next 32 beats (33..64) load correctly (o_a[0][0]=33).
- Stray i_validResult during LOAD_A/LOAD_B/FIRE → no state change; full load still needs 32 beats.
- i_clear after 10 beats of A (with i_valid=1 same cycle) → beat dropped, counters 0; next 32 beats form the full matrices, o_a[0][0]=first new byte.
- Async reset asserted in WAIT and in LOAD_B, plus an N=3 build → all outputs zero, o_ready=1 after release; N=3 needs 18 beats, o_b[2][2]=byte 18.
